// File: rtl/alu_cmd_sequencer.sv
// Command front end for the combinational ALU: FIFO-buffered commands, one-cycle issue, registered result.
// Define ALU_SEQ_FLAGS_EN to add the registered res_zero / res_parity result flags.
module alu_cmd_sequencer #(
   parameter int WIDTH      = 8,
   parameter int OPW        = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_OP     = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OPW-1:0]   cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_instr,
   input  logic [WIDTH-1:0] alu_f,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_err,
   output logic [WIDTH-1:0] acc,
`ifdef ALU_SEQ_FLAGS_EN
   output logic             res_zero,
   output logic             res_parity,
`endif
   output logic             busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state, state_nxt;
   logic [OPW-1:0]   fifo_op  [FIFO_DEPTH];
   logic [WIDTH-1:0] fifo_a   [FIFO_DEPTH];
   logic [WIDTH-1:0] fifo_b   [FIFO_DEPTH];
   logic             fifo_sel [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             push, pop, capture, op_legal, fifo_nonempty;

   assign cmd_ready     = (count < CW'(FIFO_DEPTH));
   assign push          = cmd_valid && cmd_ready;
   assign fifo_nonempty = (count != '0);
   assign busy          = fifo_nonempty || (state != IDLE);
   assign op_legal      = (alu_instr <= OPW'(MAX_OP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (fifo_nonempty) state_nxt = ISSUE;
         ISSUE:   state_nxt = RESP;
         RESP:    if (res_valid && res_ready) state_nxt = fifo_nonempty ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop     = 1'b0;
      capture = 1'b0;
      unique case (state)
         IDLE:    pop = fifo_nonempty;
         ISSUE:   capture = 1'b1;
         RESP:    pop = res_valid && res_ready && fifo_nonempty;
         default: ;
      endcase
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr]  <= cmd_op;
         fifo_a[wr_ptr]   <= cmd_a;
         fifo_b[wr_ptr]   <= cmd_b;
         fifo_sel[wr_ptr] <= cmd_acc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // acc is sampled at pop time, so a chained command sees the previous result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_instr <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
         acc       <= '0;
      end else begin
         if (pop) begin
            alu_instr <= fifo_op[rd_ptr];
            alu_b     <= fifo_b[rd_ptr];
            alu_a     <= fifo_sel[rd_ptr] ? acc : fifo_a[rd_ptr];
         end
         if (capture) begin
            res_valid <= 1'b1;
            if (op_legal) begin
               res_data <= alu_f;
               res_err  <= 1'b0;
               acc      <= alu_f;
            end else begin
               res_data <= '0;
               res_err  <= 1'b1;
            end
         end else if (state == RESP && res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_zero   <= 1'b0;
         res_parity <= 1'b0;
      end else if (capture) begin
         res_zero   <= op_legal ? (alu_f == '0) : 1'b1;
         res_parity <= op_legal ? (^alu_f) : 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU stub and in-order result model.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_cmd_sequencer;

   typedef struct packed {
      logic [7:0] data;
      logic       err;
      logic       zero;
      logic       parity;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = '0;
   logic [7:0] cmd_a = '0;
   logic [7:0] cmd_b = '0;
   logic       cmd_acc = 1'b0;
   logic [7:0] alu_a, alu_b, alu_f;
   logic [3:0] alu_instr;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_data;
   logic       res_err;
   logic [7:0] acc;
   logic       busy;
   logic       res_zero_w, res_parity_w;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] model_acc = '0;
   res_t       exp_q[$];
   res_t       obs_q[$];
   bit         push_done;

   always #5 clk = ~clk;

   alu_cmd_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr), .alu_f(alu_f),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .acc(acc),
`ifdef ALU_SEQ_FLAGS_EN
      .res_zero(res_zero_w), .res_parity(res_parity_w),
`endif
      .busy(busy)
   );

`ifndef ALU_SEQ_FLAGS_EN
   assign res_zero_w   = 1'b0;
   assign res_parity_w = 1'b0;
`endif

   function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] rot;
      rot = {a, a} << b[2:0];
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a | b;
         4'd3:    return ~a;
         4'd4:    return a << b[2:0];
         4'd5:    return rot[15:8];
         4'd6:    return a & b;
         4'd7:    return a >> b[2:0];
         4'd8:    return b;
         4'd9:    return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_f = alu_ref(alu_instr, alu_a, alu_b);

   // Commands complete strictly in order, so the expected result is known at acceptance.
   function automatic void model_push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic sel);
      res_t e;
      logic [7:0] r;
      r = alu_ref(op, sel ? model_acc : a, b);
      if (op <= 4'd9) begin
         e = '{data: r, err: 1'b0, zero: (r == 8'h00), parity: ^r};
         model_acc = r;
      end else begin
         e = '{data: 8'h00, err: 1'b1, zero: 1'b1, parity: 1'b0};
      end
      exp_q.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready)
         obs_q.push_back('{data: res_data, err: res_err, zero: res_zero_w, parity: res_parity_w});
   end

   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic sel);
      bit ok = 0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = sel; cmd_valid = 1'b1;
      for (int n = 0; n < 60 && !ok; n++) begin
         if (cmd_ready) ok = 1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (ok) model_push(op, a, b, sel);
      else begin
         checks++; failures++;
         $display("[TB] FAIL cmd_accept_timeout: cmd_ready=%b, required 1 within 60 cycles", cmd_ready);
      end
   endtask

   task automatic wait_results(input int n);
      for (int i = 0; i < 300 && obs_q.size() < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cmd_valid = 1'b0; res_ready = 1'b0;
      rst_n = 1'b1; #1; rst_n = 1'b0; #3;
      model_acc = '0; exp_q.delete(); obs_q.delete();
      checks++;
      if (res_valid !== 1'b0 || res_data !== 8'h00 || res_err !== 1'b0 || acc !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_result: valid=%b data=%h err=%b acc=%h, required 0 00 0 00", res_valid, res_data, res_err, acc);
      end
      checks++;
      if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_instr !== 4'h0) begin
         failures++;
         $display("[TB] FAIL reset_alu: a=%h b=%h instr=%h, required 00 00 0", alu_a, alu_b, alu_instr);
      end
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_status: busy=%b cmd_ready=%b, required 0 1", busy, cmd_ready);
      end
`ifdef ALU_SEQ_FLAGS_EN
      checks++;
      if (res_zero_w !== 1'b0 || res_parity_w !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags: zero=%b parity=%b, required 0 0", res_zero_w, res_parity_w);
      end
`endif
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      exp_q.delete(); obs_q.delete();
      res_ready = 1'b0;
      applyStimulus(4'd0, 8'h7F, 8'h01, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (alu_instr !== 4'd0 || alu_a !== 8'h7F || alu_b !== 8'h01) begin
         failures++;
         $display("[TB] FAIL single_issue: instr=%h a=%h b=%h, required 0 7f 01", alu_instr, alu_a, alu_b);
      end
      checks++;
      if (res_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_early_valid: res_valid=%b, required 0", res_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'h80 || res_err !== 1'b0 || acc !== 8'h80) begin
         failures++;
         $display("[TB] FAIL single_result: valid=%b data=%h err=%b acc=%h, required 1 80 0 80", res_valid, res_data, res_err, acc);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_drain: valid=%b busy=%b, required 0 0", res_valid, busy);
      end
   endtask

   task automatic test_chain();
      logic [7:0] want [3];
      want[0] = 8'h15; want[1] = 8'h12; want[2] = 8'h21;
      exp_q.delete(); obs_q.delete();
      res_ready = 1'b1;
      applyStimulus(4'd0, 8'h10, 8'h05, 1'b0);
      applyStimulus(4'd1, 8'hEE, 8'h03, 1'b1);
      applyStimulus(4'd5, 8'hEE, 8'h04, 1'b1);
      wait_results(3);
      checks++;
      if (obs_q.size() != 3) begin
         failures++;
         $display("[TB] FAIL chain_count: got %0d results, required 3", obs_q.size());
      end
      for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i].data !== want[i] || obs_q[i].err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL chain_result[%0d]: data=%h err=%b, required %h 0", i, obs_q[i].data, obs_q[i].err, want[i]);
         end
      end
      checks++;
      if (acc !== 8'h21) begin
         failures++;
         $display("[TB] FAIL chain_acc: acc=%h, required 21", acc);
      end
   endtask

   task automatic test_illegal();
      logic [7:0] acc_before;
      acc_before = model_acc;
      exp_q.delete(); obs_q.delete();
      res_ready = 1'b1;
      applyStimulus(4'hC, 8'h55, 8'hAA, 1'b0);
      wait_results(1);
      checks++;
      if (obs_q.size() < 1 || obs_q[0].data !== 8'h00 || obs_q[0].err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL illegal_result: count=%0d data=%h err=%b, required 1 00 1", obs_q.size(), res_data, res_err);
      end
      checks++;
      if (acc !== acc_before) begin
         failures++;
         $display("[TB] FAIL illegal_acc: acc=%h, required %h", acc, acc_before);
      end
      applyStimulus(4'd6, 8'hF0, 8'h3C, 1'b0);
      wait_results(2);
      checks++;
      if (obs_q.size() < 2 || obs_q[1].data !== 8'h30 || obs_q[1].err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL illegal_next: count=%0d, required 2 results with data 30 err 0", obs_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] ops [6];
      logic [7:0] as  [6];
      logic [7:0] bs  [6];
      int accepted = 0;
      bit take;
      for (int i = 0; i < 6; i++) begin
         ops[i] = 4'($urandom_range(0, 9));
         as[i]  = 8'($urandom);
         bs[i]  = 8'($urandom);
      end
      exp_q.delete(); obs_q.delete();
      res_ready = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         take = 0;
         if (accepted < 6) begin
            cmd_valid = 1'b1; cmd_op = ops[accepted]; cmd_a = as[accepted];
            cmd_b = bs[accepted]; cmd_acc = 1'b0;
         end else cmd_valid = 1'b0;
         if (cmd_valid && cmd_ready) begin
            model_push(ops[accepted], as[accepted], bs[accepted], 1'b0);
            take = 1;
         end
         @(posedge clk); #1;
         if (take) accepted++;
      end
      checks++;
      if (accepted != 5 || cmd_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_accepted: accepted=%0d cmd_ready=%b, required 5 0", accepted, cmd_ready);
      end
      checks++;
      if (res_valid !== 1'b1 || obs_q.size() != 0 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_hold: valid=%b delivered=%0d busy=%b, required 1 0 1", res_valid, obs_q.size(), busy);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      wait_results(5);
      checks++;
      if (obs_q.size() != 5) begin
         failures++;
         $display("[TB] FAIL bp_count: got %0d results, required 5", obs_q.size());
      end
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err) begin
            failures++;
            $display("[TB] FAIL bp_result[%0d]: data=%h err=%b, required %h %b", i, obs_q[i].data, obs_q[i].err, exp_q[i].data, exp_q[i].err);
         end
      end
   endtask

   task automatic test_random();
      exp_q.delete(); obs_q.delete();
      push_done = 0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               applyStimulus(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            end
            push_done = 1;
         end
         begin
            for (int g = 0; g < 3000 && !push_done; g++) begin
               res_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            res_ready = 1'b1;
         end
      join
      wait_results(exp_q.size());
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("[TB] FAIL rand_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i].data !== exp_q[i].data || obs_q[i].err !== exp_q[i].err) begin
            failures++;
            $display("[TB] FAIL rand_result[%0d]: data=%h err=%b, required %h %b", i, obs_q[i].data, obs_q[i].err, exp_q[i].data, exp_q[i].err);
         end
`ifdef ALU_SEQ_FLAGS_EN
         checks++;
         if (obs_q[i].zero !== exp_q[i].zero || obs_q[i].parity !== exp_q[i].parity) begin
            failures++;
            $display("[TB] FAIL rand_flags[%0d]: zero=%b parity=%b, required %b %b", i, obs_q[i].zero, obs_q[i].parity, exp_q[i].zero, exp_q[i].parity);
         end
`endif
      end
      checks++;
      if (acc !== model_acc) begin
         failures++;
         $display("[TB] FAIL rand_acc: acc=%h, required %h", acc, model_acc);
      end
   endtask

`ifdef ALU_SEQ_FLAGS_EN
   task automatic test_flags();
      exp_q.delete(); obs_q.delete();
      res_ready = 1'b1;
      applyStimulus(4'd1, 8'h22, 8'h22, 1'b0);
      applyStimulus(4'd9, 8'h01, 8'h06, 1'b0);
      wait_results(2);
      checks++;
      if (obs_q.size() < 2 || obs_q[0].zero !== 1'b1 || obs_q[0].parity !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flags_sub: count=%0d, required zero=1 parity=0 on first result", obs_q.size());
      end
      checks++;
      if (obs_q.size() < 2 || obs_q[1].data !== 8'h07 || obs_q[1].zero !== 1'b0 || obs_q[1].parity !== 1'b1) begin
         failures++;
         $display("[TB] FAIL flags_xor: count=%0d, required data=07 zero=0 parity=1 on second result", obs_q.size());
      end
   endtask
`endif

   task automatic test_reset_midop();
      exp_q.delete(); obs_q.delete();
      res_ready = 1'b0;
      applyStimulus(4'd0, 8'($urandom), 8'($urandom), 1'b0);
      applyStimulus(4'd2, 8'($urandom), 8'($urandom), 1'b0);
      applyStimulus(4'd6, 8'($urandom), 8'($urandom), 1'b0);
      for (int i = 0; i < 20 && !res_valid; i++) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      model_acc = '0; exp_q.delete(); obs_q.delete();
      checks++;
      if (res_valid !== 1'b0 || acc !== 8'h00 || busy !== 1'b0 || res_data !== 8'h00) begin
         failures++;
         $display("[TB] FAIL midreset_async: valid=%b acc=%h busy=%b data=%h, required 0 00 0 00", res_valid, acc, busy, res_data);
      end
      @(negedge clk); rst_n = 1'b1;
      res_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() != 0 || res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_stale: results=%0d valid=%b busy=%b, required 0 0 0", obs_q.size(), res_valid, busy);
      end
      applyStimulus(4'd0, 8'hFF, 8'h0A, 1'b1);
      wait_results(1);
      checks++;
      if (obs_q.size() != 1 || acc !== 8'h0A) begin
         failures++;
         $display("[TB] FAIL midreset_after: results=%0d acc=%h, required 1 0a", obs_q.size(), acc);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_chain();
      test_illegal();
      test_backpressure();
      test_random();
`ifdef ALU_SEQ_FLAGS_EN
      test_flags();
`endif
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side front end for the 8-bit combinational ALU; this block is the initiator that drives the ALU's operands and opcode and collects its F result.
- Accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Issues each command to the ALU, registers the result, and returns it over a second valid/ready stream.
- Keeps an accumulator so operations can be chained without re-sending operand A.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- OPW, 4, opcode width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- MAX_OP, 9, highest legal opcode; opcodes above this are rejected.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  OPW  ALU opcode.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_acc  in  1  use the accumulator instead of cmd_a as operand A.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_instr  out  OPW  to ALU instruction.
- alu_f  in  WIDTH  from ALU F (combinational).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  registered result.
- res_err  out  1  result belongs to a rejected (illegal) opcode.
- acc  out  WIDTH  current accumulator value.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; FIFO empty; acc=0; res_valid=0; res_data=0; res_err=0; alu_a=0; alu_b=0; alu_instr=0; busy=0.
- cmd_ready = (count < FIFO_DEPTH).
  - Depends on count only; it does not rise on a same-cycle pop.
  - A push happens when cmd_valid && cmd_ready.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo FIFO_DEPTH.
- Each FIFO entry holds {op, a, b, acc_sel}.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop the head into the issue registers and go to ISSUE. alu_a/alu_b/alu_instr are loaded from the entry on this same edge. alu_a = acc when acc_sel=1, else a.
  - ISSUE (exactly 1 cycle): ALU inputs are stable.
    - Legal op: at the edge, capture res_data=alu_f, res_err=0, acc=alu_f.
    - Illegal op (op > MAX_OP): res_data=0, res_err=1, acc unchanged.
    - In both cases set res_valid=1 and go to RESP.
  - RESP: hold res_valid, res_data and res_err stable until res_valid && res_ready.
    - On that edge res_valid=0.
    - If the FIFO is non-empty, pop the next entry into the issue registers and go straight to ISSUE; otherwise go to IDLE.
- Latency: a command pushed at edge N into an empty, idle block has res_valid high after edge N+2.
- Throughput: one result per 2 cycles with res_ready held high.
- acc_sel reads acc as it stands at pop time, so chained commands see the previous command's result.
- alu_* outputs hold their last values outside ISSUE; they are never X.
- Backpressure: while in RESP, commands keep filling the FIFO until full. No command is ever dropped.
- Reset mid-operation: the in-flight command and all FIFO contents are discarded and every output returns to its reset value.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- Defined:
  - Adds output res_zero (1 bit), = (res_data == 0), registered with res_data, reset 0.
  - Adds output res_parity (1 bit), = XOR-reduce of res_data, registered with res_data, reset 0.
  - Both are valid only while res_valid=1.
  - For rejected opcodes: res_zero=1, res_parity=0.
- Undefined: neither port exists. All other behaviour is identical.

Test Plan:
- Single command: op=0 (ADD), a=0x7F, b=0x01, acc_sel=0. Expect alu_instr=0, alu_a=0x7F, alu_b=0x01 in ISSUE. Expect res_valid 2 cycles after acceptance, res_data=0x80, res_err=0, acc=0x80.
- Chain: ADD 0x10+0x05, then SUB with acc_sel=1, b=0x03, then op=5 (rotate left) with acc_sel=1, b=4. Expect results 0x15, 0x12, 0x21 in order, and final acc=0x21.
- Backpressure/full: hold res_ready=0 and push 6 commands back-to-back.
  - cmd_ready drops after 4 FIFO pushes plus 1 popped in flight. Pushes stop at exactly FIFO_DEPTH+1 accepted.
  - Release res_ready; all 5 results arrive in order with no loss.
- Illegal opcode: op=0xC, a=0x55, b=0xAA. Expect res_data=0x00, res_err=1, acc unchanged. Next legal command op=6 (AND) 0xF0&0x3C gives 0x30, res_err=0.
- Reset mid-op: assert rst_n=0 while in RESP with 2 commands queued. Expect res_valid=0, acc=0, busy=0 immediately (async). After release, no stale results appear.
- Flags (ALU_SEQ_FLAGS_EN): op=1 (SUB) 0x22−0x22 gives res_zero=1, res_parity=0. op=9 (XOR) 0x01^0x06 = 0x07 gives res_zero=0, res_parity=1.
